// File: rtl/vx_ti_pkg.sv
// Shared definitions for the triangle-intersect fetch path: size codes, their
// byte lengths, and the fetch arbiter state encoding.
package vx_ti_pkg;

  localparam logic [1:0] TI_SIZE_IDX     = 2'd0;  // 4 B triangle index
  localparam logic [1:0] TI_SIZE_BVH     = 2'd1;  // 32 B BVH node
  localparam logic [1:0] TI_SIZE_TRI     = 2'd2;  // 48 B triangle node
  localparam logic [1:0] TI_SIZE_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } ti_arb_state_e;

  function automatic int ti_size_bytes(input logic [1:0] size);
    case (size)
      TI_SIZE_IDX: return 4;
      TI_SIZE_BVH: return 32;
      TI_SIZE_TRI: return 48;
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/vx_ti_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first set mask bit
// found searching upward from i_ptr+1, wrapping past NUM_REQS-1.
module vx_ti_rr_pick #(
  parameter int NUM_REQS = 4,
  parameter int PTR_BITS = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] i_mask,
  input  logic [PTR_BITS-1:0] i_ptr,
  output logic [NUM_REQS-1:0] o_grant
);

  logic [PTR_BITS-1:0] w_idx;

  // Walk the distances from farthest to nearest so the nearest candidate wins.
  always_comb begin
    o_grant = '0;
    w_idx   = '0;
    for (int k = NUM_REQS; k >= 1; k--) begin
      w_idx = PTR_BITS'((int'(i_ptr) + k) % NUM_REQS);
      if (i_mask[w_idx]) begin
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_ti_fetch_arb.sv
// Fetch arbiter: round-robin grant of one traversal-unit request at a time to
// the shared fetch engine. Optional perf counters under TI_FETCH_ARB_PERF_EN.
//
// Handshakes: req_valid/req_ready and rsp_valid/rsp_ready transfer in a cycle
// where both are high; once valid is raised by the arbiter it stays high with
// stable payload until accepted. mem_start is a single-cycle pulse only while
// mem_ready is high; mem_valid is a single-cycle data pulse.
module vx_ti_fetch_arb
  import vx_ti_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 384
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  output logic [NUM_REQS-1:0]           req_ready,
  input  logic [NUM_REQS*ADDR_BITS-1:0] req_addr,
  input  logic [NUM_REQS*2-1:0]         req_size,
  output logic [NUM_REQS-1:0]           rsp_valid,
  input  logic [NUM_REQS-1:0]           rsp_ready,
  output logic [DATA_BITS-1:0]          rsp_data,
  output logic                          rsp_err,
  output logic                          mem_start,
  output logic [ADDR_BITS-1:0]          mem_addr,
  output logic [1:0]                    mem_size,
  input  logic                          mem_ready,
  input  logic                          mem_valid,
  input  logic [DATA_BITS-1:0]          mem_data,
  output logic [1:0]                    dbg_state
`ifdef TI_FETCH_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_grants,
  output logic [31:0]                   perf_stalls
`endif
);

  localparam int PTR_BITS = $clog2(NUM_REQS);

  ti_arb_state_e         r_state, w_next;
  logic [PTR_BITS-1:0]   r_last, r_gnt, w_gnt_idx;
  logic [NUM_REQS-1:0]   w_gnt_oh;
  logic [ADDR_BITS-1:0]  r_addr, w_sel_addr;
  logic [1:0]            r_size, w_sel_size;
  logic [DATA_BITS-1:0]  r_rsp_data, w_size_mask;
  logic                  r_err, w_any, w_grant, w_sel_err;

  vx_ti_rr_pick #(
    .NUM_REQS (NUM_REQS),
    .PTR_BITS (PTR_BITS)
  ) u_pick (
    .i_mask  (req_valid),
    .i_ptr   (r_last),
    .o_grant (w_gnt_oh)
  );

  always_comb begin
    w_gnt_idx  = '0;
    w_sel_addr = '0;
    w_sel_size = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_gnt_oh[i]) begin
        w_gnt_idx  = PTR_BITS'(i);
        w_sel_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
        w_sel_size = req_size[i*2 +: 2];
      end
    end
  end

  assign w_any     = |req_valid;
  assign w_grant   = (r_state == ST_IDLE) && w_any && reset;
  assign w_sel_err = (w_sel_size == TI_SIZE_ILLEGAL) || (w_sel_addr[1:0] != 2'b00);

  always_comb begin
    w_size_mask = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      w_size_mask[i] = (i < ti_size_bytes(r_size) * 8);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Malformed requests skip the fetch engine entirely and answer with an error.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant) w_next = w_sel_err ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (mem_ready) w_next = ST_WAIT;
      ST_WAIT:  if (mem_valid) w_next = ST_RESP;
      ST_RESP:  if (rsp_ready[r_gnt]) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mem_start = 1'b0;
    case (r_state)
      ST_IDLE:  if (reset) req_ready = w_gnt_oh;
      ST_ISSUE: mem_start = mem_ready;
      ST_RESP:  rsp_valid[r_gnt] = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last     <= PTR_BITS'(NUM_REQS - 1);
      r_gnt      <= '0;
      r_addr     <= '0;
      r_size     <= '0;
      r_err      <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      if (w_grant) begin
        r_gnt      <= w_gnt_idx;
        r_addr     <= w_sel_addr;
        r_size     <= w_sel_size;
        r_err      <= w_sel_err;
        r_rsp_data <= '0;
      end
      if (r_state == ST_WAIT && mem_valid) r_rsp_data <= mem_data & w_size_mask;
      if (r_state == ST_RESP && rsp_ready[r_gnt]) r_last <= r_gnt;
    end
  end

  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_err;
  assign mem_addr  = r_addr;
  assign mem_size  = r_size;
  assign dbg_state = r_state;

`ifdef TI_FETCH_ARB_PERF_EN
  logic [31:0] r_perf_grants, r_perf_stalls;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_grants <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_grant && !w_sel_err) r_perf_grants <= r_perf_grants + 32'd1;
      if (w_any && r_state != ST_IDLE) r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign perf_grants = r_perf_grants;
  assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_vx_ti_fetch_arb.sv
// Bench for vx_ti_fetch_arb: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_vx_ti_fetch_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 384;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*2-1:0]  req_size = '0;
  logic [DW-1:0]   rsp_data, mem_data = '0;
  logic            rsp_err, mem_start, mem_ready = 1'b0, mem_valid = 1'b0;
  logic [AW-1:0]   mem_addr;
  logic [1:0]      mem_size, dbg_state;
`ifdef TI_FETCH_ARB_PERF_EN
  logic [31:0]     perf_grants, perf_stalls;
`endif

  vx_ti_fetch_arb #(.NUM_REQS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_start (mem_start),
    .mem_addr  (mem_addr),
    .mem_size  (mem_size),
    .mem_ready (mem_ready),
    .mem_valid (mem_valid),
    .mem_data  (mem_data),
    .dbg_state (dbg_state)
`ifdef TI_FETCH_ARB_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_stalls (perf_stalls)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  int n_vec = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];   // expected response payload of the one outstanding transaction
  int grant_q[$];            // grant order as predicted by the model
  bit m_free = 1, m_issue = 0, m_wait = 0, m_rsp = 0, m_err = 0;
  int m_last = N - 1;
  int m_own = 0;
  logic [AW-1:0] m_addr = '0;
  logic [1:0] m_size = '0;

  // fetch-engine stand-in controls
  bit start_seen = 0, ready_rand = 0, spur_rand = 0, spur_next = 0, data_ones = 0, rand_inputs = 0;
  int pend = 0, cnt = 0, lat_fix = -1, ready_low_n = 0, dut_starts = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // Compare DUT outputs with the model for this cycle, then advance the model.
  task automatic model_check();
    logic [N-1:0]  e_ready, e_rsp;
    logic [DW-1:0] one, mask;
    int g, bytes;
    if (!reset) begin
      chk("rst_req_ready", req_ready, '0);
      chk("rst_rsp_valid", rsp_valid, '0);
      chk("rst_rsp_err", rsp_err, '0);
      chk("rst_mem_start", mem_start, '0);
      chk("rst_rsp_data", rsp_data, '0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_size", mem_size, '0);
      chk("rst_state", dbg_state, vx_ti_pkg::ST_IDLE);
      m_free = 1; m_issue = 0; m_wait = 0; m_rsp = 0; m_last = N - 1;
      exp_q.delete();
      return;
    end
    e_ready = '0;
    g = -1;
    if (m_free) begin
      for (int k = 1; k <= N; k++) begin
        int idx = (m_last + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) e_ready[g] = 1'b1;
    e_rsp = '0;
    if (m_rsp) e_rsp[m_own] = 1'b1;
    chk("req_ready", req_ready, e_ready);
    chk("mem_start", mem_start, m_issue && mem_ready);
    chk("rsp_valid", rsp_valid, e_rsp);
    if (m_rsp) begin
      chk("rsp_data", rsp_data, exp_q[0]);
      chk("rsp_err", rsp_err, m_err);
    end
    if (m_issue || m_wait) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_size", mem_size, m_size);
    end
    if (g >= 0) begin
      grant_q.push_back(g);
      m_own  = g;
      m_addr = req_addr[g*AW +: AW];
      m_size = req_size[g*2 +: 2];
      m_free = 0;
      if (m_size == 2'd3 || m_addr[1:0] != 2'b00) begin
        m_err = 1; m_rsp = 1; exp_q.push_back('0);
      end else begin
        m_err = 0; m_issue = 1;
      end
    end else if (m_issue) begin
      if (mem_ready) begin m_issue = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (mem_valid) begin
        bytes = (m_size == 2'd0) ? 4 : (m_size == 2'd1) ? 32 : 48;
        one  = 1;
        mask = (one << (bytes * 8)) - one;
        exp_q.push_back(mem_data & mask);
        m_wait = 0; m_rsp = 1;
      end
    end else if (m_rsp) begin
      if (rsp_ready[m_own]) begin
        m_rsp = 0; m_free = 1; m_last = m_own; exp_q.delete();
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_mem();
    mem_valid = 1'b0;
    if (!reset) begin
      pend = 0;
    end else begin
      if (start_seen) begin
        pend = 1;
        cnt  = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 5);
      end
      if (pend != 0) begin
        if (cnt == 0) begin
          mem_valid = 1'b1; mem_data = data_ones ? '1 : rand_data(); pend = 0;
        end else cnt--;
      end else if (spur_next || (spur_rand && $urandom_range(0, 15) == 0)) begin
        mem_valid = 1'b1; mem_data = rand_data();
      end
    end
    spur_next = 0;
    if (ready_low_n > 0) begin
      mem_ready = 1'b0; ready_low_n--;
    end else mem_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic randomize_inputs();
    logic [AW-1:0] a;
    int r;
    reset     = ($urandom_range(0, 399) != 0);
    req_valid = N'($urandom_range(0, 15));
    rsp_ready = N'($urandom_range(0, 15));
    for (int i = 0; i < N; i++) begin
      a = $urandom();
      a[1:0] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      req_addr[i*AW +: AW] = a;
      r = $urandom_range(0, 9);
      req_size[i*2 +: 2] = (r == 0) ? 2'd3 : 2'(r % 3);
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic step();
    model_check();
    start_seen = mem_start;
    if (mem_start) dut_starts++;
    @(posedge clk);
    #1;
    drive_mem();
    if (rand_inputs) randomize_inputs();
  endtask

  task automatic tick();
    neg();
    step();
  endtask

  task automatic wait_grants(input int n, input string name);
    int budget = 300;
    while (grant_q.size() < n && budget > 0) begin tick(); budget--; end
    n_vec++;
    if (grant_q.size() < n) begin
      n_fail++;
      $display("FAIL %s: timeout with %0d grants, expected %0d", name, grant_q.size(), n);
    end
  endtask

  task automatic wait_free(input string name);
    int budget = 300;
    while (!m_free && budget > 0) begin tick(); budget--; end
    n_vec++;
    if (!m_free) begin n_fail++; $display("FAIL %s: timeout, transaction never retired", name); end
  endtask

  task automatic wait_rsp(input string name);
    int budget = 300;
    while (!m_rsp && budget > 0) begin tick(); budget--; end
    n_vec++;
    if (!m_rsp) begin n_fail++; $display("FAIL %s: timeout, response never arrived", name); end
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = '0; rsp_ready = '0;
    tick(); tick();
    reset = 1'b1;
    grant_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int s0;
    logic [DW-1:0] d_exp;

    do_reset();

    // A: 0110 after reset -> 1 then 2, start one cycle after accept
    req_addr  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
    req_size  = 8'b01_01_01_01;
    rsp_ready = 4'hF;
    req_valid = 4'b0110;
    neg(); chk("a_first_grant", req_ready, 4'b0010); step();
    neg(); chk("a_first_start", mem_start, 1'b1); step();
    wait_grants(2, "a_grants");
    req_valid = '0;
    wait_free("a_drain");
    if (grant_q.size() >= 2) begin
      chk("a_grant_0", grant_q[0], 1);
      chk("a_grant_1", grant_q[1], 2);
    end

    // B: all requesters continuously valid -> 0,1,2,3,0,1,2,3
    do_reset();
    for (int i = 0; i < N; i++) req_size[i*2 +: 2] = 2'($urandom_range(0, 2));
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    wait_grants(8, "b_grants");
    req_valid = '0;
    wait_free("b_drain");
    for (int i = 0; i < 8; i++) if (i < grant_q.size()) chk("b_order", grant_q[i], exp_order[i]);

    // C: illegal size, then misaligned address -> error at cycle 1, no fetch
    do_reset();
    s0 = dut_starts;
    rsp_ready = 4'hF;
    req_addr[31:0] = 32'h0000_1000;
    req_size[1:0]  = 2'd3;
    req_valid      = 4'b0001;
    neg(); chk("c_size3_grant", req_ready, 4'b0001); step();
    req_valid = '0;
    neg();
    chk("c_size3_rsp_valid", rsp_valid, 4'b0001);
    chk("c_size3_err", rsp_err, 1'b1);
    chk("c_size3_data", rsp_data, '0);
    chk("c_size3_no_start", mem_start, 1'b0);
    step();
    req_addr[31:0] = 32'h0000_1002;
    req_size[1:0]  = 2'd1;
    req_valid      = 4'b0001;
    neg(); chk("c_misal_grant", req_ready, 4'b0001); step();
    req_valid = '0;
    neg();
    chk("c_misal_rsp_valid", rsp_valid, 4'b0001);
    chk("c_misal_err", rsp_err, 1'b1);
    chk("c_misal_data", rsp_data, '0);
    step();
    tick();
    chk("c_start_count", dut_starts - s0, 0);

    // D: 4 B fetch of all-ones, response held 5 cycles with others waiting
    req_addr[63:32] = 32'h0000_2000;
    req_size[3:2]   = 2'd0;
    rsp_ready       = '0;
    data_ones       = 1;
    req_valid       = 4'b0010;
    wait_rsp("d_rsp");
    req_valid = 4'hF;
    d_exp = '0;
    d_exp[31:0] = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("d_rsp_valid", rsp_valid, 4'b0010);
      chk("d_rsp_data", rsp_data, d_exp);
      chk("d_rsp_err", rsp_err, 1'b0);
      chk("d_no_grant", req_ready, '0);
      step();
    end
    req_valid = '0;
    rsp_ready = 4'hF;
    data_ones = 0;
    wait_free("d_drain");

    // E: mem_ready low 3 cycles in ISSUE, then reset in WAIT and a stray mem_valid
    do_reset();
    s0 = dut_starts;
    lat_fix = 10;
    rsp_ready = 4'hF;
    req_addr[31:0] = 32'h0000_0040;
    req_size[1:0]  = 2'd1;
    req_valid      = 4'b0001;
    ready_low_n    = 3;
    neg(); chk("e_grant", req_ready, 4'b0001); step();
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      neg(); chk("e_start_cycle", mem_start, i == 3); step();
    end
    chk("e_one_start", dut_starts - s0, 1);
    neg();
    chk("e_mem_addr", mem_addr, 32'h0000_0040);
    chk("e_mem_size", mem_size, 2'd1);
    step();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    spur_next = 1;
    for (int i = 0; i < 4; i++) begin
      neg(); chk("e_no_rsp", rsp_valid, '0); step();
    end
    lat_fix = -1;

    // F: randomized traffic with back-pressure, stray data pulses and resets
    do_reset();
    ready_rand  = 1;
    spur_rand   = 1;
    rand_inputs = 1;
    repeat (3000) tick();
    rand_inputs = 0;
    spur_rand   = 0;
    ready_rand  = 0;
    reset       = 1'b1;
    req_valid   = '0;
    rsp_ready   = 4'hF;
    wait_free("f_drain");

`ifdef TI_FETCH_ARB_PERF_EN
    // G: three good grants and one error grant
    do_reset();
    rsp_ready = 4'hF;
    req_addr[31:0] = 32'h0000_0080;
    for (int t = 0; t < 4; t++) begin
      req_size[1:0] = (t == 2) ? 2'd3 : 2'd2;
      req_valid = 4'b0001;
      wait_grants(t + 1, "g_grant");
      req_valid = '0;
      wait_free("g_drain");
    end
    chk("g_perf_grants", perf_grants, 32'd3);
    chk("g_perf_stalls", perf_stalls, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
